mem_wb_pipe: RTL and testbench
==============================

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 32: width of memory-read data, ALU result and write-back data.
REQ-002 Parameter REG_AW, default 5: register-address width.
REQ-003 Parameter LOAD_EXT, default 1: 1 = byte/half load extraction enabled; 0 = memory data passes unmodified.
REQ-004 Port clk  in  1: single clock; all state captured on falling edge (negedge clk), matching pipeline register convention.
REQ-005 Port reset  in  1: synchronous, active-high, sampled on negedge clk.
REQ-006 Port in_valid  in  1; in_ready  out  1: MEM-side handshake, transfer when both high at capture edge.
REQ-007 Port dato_mem  in  DATA_W; ALU  in  DATA_W; rd  in  REG_AW; rt  in  REG_AW: payload.
REQ-008 Port reg_write  in  1; mem_to_reg  in  1; dst_rt  in  1 (1 = destination rt, 0 = rd); ld_size  in  2 (0 byte, 1 half, 2 word); ld_signed  in  1.
REQ-009 Port flush  in  1: discard all held entries.
REQ-010 Port out_valid  out  1; out_ready  in  1: WB-side handshake.
REQ-011 Port wb_data  out  DATA_W; wb_addr  out  REG_AW; wb_en  out  1.
REQ-012 Port fwd_valid  out  1; fwd_addr  out  REG_AW; fwd_data  out  DATA_W: forwarding tap of the output entry.

Function
REQ-013 Storage: main entry (drives outputs) plus one skid entry; each with valid bit.
REQ-014 in_ready SHALL be registered, equal to NOT skid_valid.
REQ-015 Empty main, accept: input loads main; out_valid high next edge (latency 1 capture edge).
REQ-016 Main valid and out_ready high: main retires; replaced by skid if valid, else by accepted input, else main_valid cleared.
REQ-017 Main valid, out_ready low, input accepted: input loads skid; in_ready drops next edge.
REQ-018 Skid valid and out_ready high: skid moves to main, skid cleared, in_ready rises; no input accepted that edge.
REQ-019 Order preserved: entries SHALL leave in acceptance order; no entry lost or duplicated.
REQ-020 wb_addr = rt when dst_rt, else rd; computed at capture, stored.
REQ-021 Load extract (LOAD_EXT=1, mem_to_reg=1): byte lane = ALU[1:0], half lane = ALU[1]; sign- or zero-extend to DATA_W per ld_signed; word passes.
REQ-022 wb_data = extracted memory data when mem_to_reg, else ALU; computed at capture, stored.
REQ-023 wb_en = out_valid AND stored reg_write AND (wb_addr != 0).
REQ-024 fwd_valid = wb_en; fwd_addr = wb_addr; fwd_data = wb_data.
REQ-025 ld_size = 3 SHALL be treated as word.
REQ-026 flush: both valids cleared at that edge; input at that edge not accepted; in_ready high next edge; flush wins over all simultaneous events.
REQ-027 out_valid and payload SHALL remain stable while out_valid high and out_ready low.

Reset
REQ-028 Reset SHALL clear main_valid, skid_valid; set in_ready 1; out_valid, wb_en, fwd_valid 0; wb_data, fwd_data 0; wb_addr, fwd_addr 0.
REQ-029 Reset mid-transfer SHALL drop all held entries; reset dominates flush and handshakes.

Structure
REQ-030 Shared package holds ld_size encodings (LD_BYTE, LD_HALF, LD_WORD) and default DATA_W/REG_AW constants.
REQ-031 Sub-module load_extract (combinational, DATA_W, LD encodings) SHALL perform REQ-021, instantiated once at the input.

Verification
REQ-032 Reset, then in_valid with ALU=0x00000010, mem_to_reg=0, rd=3, reg_write=1, out_ready=1 -> next edge out_valid=1, wb_data=0x00000010, wb_addr=3, wb_en=1.
REQ-033 out_ready=0, send A then B -> skid full, in_ready=0; raise out_ready -> A then B on successive edges, in_ready returns 1.
REQ-034 dato_mem=0x12345680, ALU[1:0]=0, ld_size=byte, ld_signed=1 -> wb_data=0xFFFFFF80; ld_signed=0 -> 0x00000080; half, ALU[1]=1 -> 0x00001234.
REQ-035 rd=0, reg_write=1 -> out_valid=1, wb_en=0, fwd_valid=0; dst_rt=1, rt=7 -> wb_addr=7.
REQ-036 Both entries full, flush with in_valid=1 same edge -> out_valid=0 next edge, nothing accepted, in_ready=1.
REQ-037 reset asserted with both entries full and out_ready=1 -> all outputs at REQ-028 values next edge, no entry emitted.

Source files
------------

// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline register: load-size encodings
// and default datapath widths.
package mem_wb_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    // Load size encodings; the unused code 2'd3 behaves as a word load.
    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2
    } ld_size_e;

endpackage

// File: rtl/mem_wb_pipe_load_extract.sv
// Combinational load-data extraction: selects the addressed byte or halfword
// lane of the memory word and sign- or zero-extends it to DATA_W.
// The lane select assumes DATA_W is 32 (four byte lanes).
module load_extract
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] dato_mem,
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    output logic [DATA_W-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the byte lane (addr_lo) and halfword lane (addr_lo[1]).
    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo)
            2'd0:    byte_sel = dato_mem[7:0];
            2'd1:    byte_sel = dato_mem[15:8];
            2'd2:    byte_sel = dato_mem[23:16];
            default: byte_sel = dato_mem[31:24];
        endcase
        half_sel = addr_lo[1] ? dato_mem[31:16] : dato_mem[15:0];
    end

    // Extend the selected lane; word and the spare encoding pass through.
    always_comb begin
        load_data = dato_mem;
        case (ld_size)
            LD_BYTE: load_data = {{(DATA_W-8){ld_signed & byte_sel[7]}}, byte_sel};
            LD_HALF: load_data = {{(DATA_W-16){ld_signed & half_sel[15]}}, half_sel};
            default: load_data = dato_mem;
        endcase
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with a one-entry skid buffer. Write-back data and
// destination address are resolved when an entry is captured, so the output
// entry directly drives the register-file write port and the forwarding tap.
// All state is captured on the falling clock edge.
//
// Handshake: a transfer happens on a capture edge where valid and ready are
// both high. in_ready is registered and depends only on skid occupancy, so
// the producer never sees a combinational path from out_ready. While
// out_valid is high and out_ready low, out_valid and payload hold steady.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int LOAD_EXT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dato_mem,
    input  logic [DATA_W-1:0] ALU,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rt,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              dst_rt,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] wb_addr,
    output logic              wb_en,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] cap_data;
    logic [REG_AW-1:0] cap_addr;

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [REG_AW-1:0] main_addr_q,  main_addr_d;
    logic              main_rw_q,    main_rw_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [REG_AW-1:0] skid_addr_q,  skid_addr_d;
    logic              skid_rw_q,    skid_rw_d;
    logic              in_ready_q;
    logic              accept;
    logic              retire;

    load_extract #(
        .DATA_W (DATA_W)
    ) u_load_extract (
        .dato_mem  (dato_mem),
        .addr_lo   (ALU[1:0]),
        .ld_size   (ld_size),
        .ld_signed (ld_signed),
        .load_data (ext_data)
    );

    // Resolve the write-back value and destination of the incoming entry.
    always_comb begin
        cap_addr = dst_rt ? rt : rd;
        cap_data = ALU;
        if (mem_to_reg) begin
            cap_data = (LOAD_EXT != 0) ? ext_data : dato_mem;
        end
    end

    // Next-state for main/skid entries; flush overrides every other event.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_addr_d  = main_addr_q;
        main_rw_d    = main_rw_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_addr_d  = skid_addr_q;
        skid_rw_d    = skid_rw_q;
        accept       = in_valid & in_ready_q;
        retire       = main_valid_q & out_ready;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so no input can be taken this edge.
            if (retire) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_addr_d  = skid_addr_q;
                main_rw_d    = skid_rw_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || retire) begin
            main_valid_d = accept;
            if (accept) begin
                main_data_d = cap_data;
                main_addr_d = cap_addr;
                main_rw_d   = reg_write;
            end
        end else if (accept) begin
            // Main is stalled: park the new entry in the skid slot.
            skid_valid_d = 1'b1;
            skid_data_d  = cap_data;
            skid_addr_d  = cap_addr;
            skid_rw_d    = reg_write;
        end
    end

    // State register, captured on the falling edge; reset dominates all.
    always_ff @(negedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_addr_q  <= '0;
            main_rw_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_addr_q  <= '0;
            skid_rw_q    <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_addr_q  <= main_addr_d;
            main_rw_q    <= main_rw_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_addr_q  <= skid_addr_d;
            skid_rw_q    <= skid_rw_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign wb_data   = main_data_q;
    assign wb_addr   = main_addr_q;
    assign wb_en     = main_valid_q & main_rw_q & (main_addr_q != '0);
    assign fwd_valid = wb_en;
    assign fwd_addr  = main_addr_q;
    assign fwd_data  = main_data_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: single-entry vectors from a table, directed
// skid/flush/reset sequences, and a randomized stream checked against an
// expected-order queue.
module tb_mem_wb_pipe;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dato_mem;
    logic [DW-1:0] alu;
    logic [AW-1:0] rd;
    logic [AW-1:0] rt;
    logic          reg_write;
    logic          mem_to_reg;
    logic          dst_rt;
    logic [1:0]    ld_size;
    logic          ld_signed;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_addr;
    logic          wb_en;
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;

    int tests_run = 0;
    int tests_failed = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] dato;
        logic [DW-1:0] alu;
        logic [AW-1:0] rd;
        logic [AW-1:0] rt;
        logic          rw;
        logic          m2r;
        logic          dst;
        logic [1:0]    size;
        logic          sgn;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_addr;
        logic          exp_en;
    } vec_t;

    vec_t vecs[13];

    mem_wb_pipe #(
        .DATA_W   (DW),
        .REG_AW   (AW),
        .LOAD_EXT (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dato_mem   (dato_mem),
        .ALU        (alu),
        .rd         (rd),
        .rt         (rt),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .dst_rt     (dst_rt),
        .ld_size    (ld_size),
        .ld_signed  (ld_signed),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr),
        .wb_en      (wb_en),
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one capture (falling) edge; sample/drive 1 ns later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver: present one ALU-result entry with write enabled.
    task automatic send_alu(input logic [DW-1:0] a, input logic [AW-1:0] r);
        in_valid   = 1'b1;
        alu        = a;
        dato_mem   = '0;
        rd         = r;
        rt         = '0;
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        dst_rt     = 1'b0;
        ld_size    = 2'd2;
        ld_signed  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_wb_en"},     {31'd0, wb_en}, 32'd0);
        check({tag, "_fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
        check({tag, "_wb_data"},   wb_data, 32'd0);
        check({tag, "_fwd_data"},  fwd_data, 32'd0);
        check({tag, "_wb_addr"},   {27'd0, wb_addr}, 32'd0);
        check({tag, "_fwd_addr"},  {27'd0, fwd_addr}, 32'd0);
    endtask

    // Fill main with A (0xA1) and skid with B (0xB2) while the sink stalls.
    task automatic fill_both();
        out_ready = 1'b0;
        send_alu(32'h0000_00A1, 5'd1);
        step();
        send_alu(32'h0000_00B2, 5'd2);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // dato, alu, rd, rt, rw, m2r, dst, size, sgn, exp_data, exp_addr, exp_en
        vecs[0]  = '{32'h0, 32'h0000_0010, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 5'd3, 1'b1};
        vecs[1]  = '{32'h1234_5680, 32'h0000_0100, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'hFFFF_FF80, 5'd4, 1'b1};
        vecs[2]  = '{32'h1234_5680, 32'h0000_0100, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0080, 5'd4, 1'b1};
        vecs[3]  = '{32'h1234_5680, 32'h0000_0102, 5'd6, 5'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_1234, 5'd6, 1'b1};
        vecs[4]  = '{32'h0, 32'h0000_0055, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0055, 5'd0, 1'b0};
        vecs[5]  = '{32'h0, 32'h0000_0077, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0077, 5'd7, 1'b1};
        vecs[6]  = '{32'h8A34_5680, 32'h0000_0003, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'hFFFF_FF8A, 5'd8, 1'b1};
        vecs[7]  = '{32'h1234_F00D, 32'h0000_0000, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'hFFFF_F00D, 5'd9, 1'b1};
        vecs[8]  = '{32'hDEAD_BEEF, 32'h0000_0001, 5'd10, 5'd0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 32'hDEAD_BEEF, 5'd10, 1'b1};
        vecs[9]  = '{32'hCAFE_F00D, 32'h0000_0003, 5'd11, 5'd0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 32'hCAFE_F00D, 5'd11, 1'b1};
        vecs[10] = '{32'h0, 32'h0000_0099, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0099, 5'd5, 1'b0};
        vecs[11] = '{32'h1234_5680, 32'h0000_0001, 5'd12, 5'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0056, 5'd12, 1'b1};
        vecs[12] = '{32'h12A4_5680, 32'h0000_0002, 5'd13, 5'd1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 32'hFFFF_FFA4, 5'd1, 1'b1};

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        dato_mem = '0; alu = '0; rd = '0; rt = '0; reg_write = 1'b0;
        mem_to_reg = 1'b0; dst_rt = 1'b0; ld_size = 2'd2; ld_signed = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Single-entry vectors: latency one capture edge, then retire.
        for (int i = 0; i < 13; i++) begin
            in_valid   = 1'b1;
            dato_mem   = vecs[i].dato;
            alu        = vecs[i].alu;
            rd         = vecs[i].rd;
            rt         = vecs[i].rt;
            reg_write  = vecs[i].rw;
            mem_to_reg = vecs[i].m2r;
            dst_rt     = vecs[i].dst;
            ld_size    = vecs[i].size;
            ld_signed  = vecs[i].sgn;
            out_ready  = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].exp_data);
            check($sformatf("vec%0d_wb_addr", i), {27'd0, wb_addr}, {27'd0, vecs[i].exp_addr});
            check($sformatf("vec%0d_wb_en", i), {31'd0, wb_en}, {31'd0, vecs[i].exp_en});
            check($sformatf("vec%0d_fwd_valid", i), {31'd0, fwd_valid}, {31'd0, vecs[i].exp_en});
            check($sformatf("vec%0d_fwd_addr", i), {27'd0, fwd_addr}, {27'd0, vecs[i].exp_addr});
            check($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].exp_data);
            step();
            check($sformatf("vec%0d_retired", i), {31'd0, out_valid}, 32'd0);
        end

        // Skid: stall, send A then B, then drain in order.
        fill_both();
        check("skid_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("skid_head_A", wb_data, 32'h0000_00A1);
        // Offer C while full and stalled: must be ignored.
        send_alu(32'h0000_00C3, 5'd3);
        step();
        check("skid_stall_hold", wb_data, 32'h0000_00A1);
        check("skid_stall_valid", {31'd0, out_valid}, 32'd1);
        check("skid_stall_in_ready", {31'd0, in_ready}, 32'd0);
        // Release with C still offered: skid moves up, C not taken this edge.
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("skid_head_B", wb_data, 32'h0000_00B2);
        check("skid_B_addr", {27'd0, wb_addr}, 32'd2);
        check("skid_in_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        check("skid_drained", {31'd0, out_valid}, 32'd0);

        // Flush with both entries full and a new input offered.
        fill_both();
        flush = 1'b1;
        send_alu(32'h0000_00D4, 5'd4);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_wb_en", {31'd0, wb_en}, 32'd0);
        out_ready = 1'b1;
        step();
        check("flush_nothing_taken", {31'd0, out_valid}, 32'd0);

        // Reset with both entries full and the sink ready.
        fill_both();
        out_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outputs("midreset");
        step();
        check("midreset_no_emit", {31'd0, out_valid}, 32'd0);

        // Randomized stream: order preserved, nothing lost or duplicated.
        begin
            logic [DW-1:0] seq;
            seq = 32'h100;
            for (int c = 0; c < 80; c++) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                alu = seq; rd = 5'd1; reg_write = 1'b1; mem_to_reg = 1'b0; dst_rt = 1'b0;
                if (in_valid && in_ready) begin
                    exp_q.push_back(seq);
                    seq = seq + 1;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("stream_extra", wb_data, 32'hFFFF_FFFF);
                    end else begin
                        check("stream_order", wb_data, exp_q.pop_front());
                    end
                end
                step();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int c = 0; c < 6; c++) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("stream_extra", wb_data, 32'hFFFF_FFFF);
                    end else begin
                        check("stream_order", wb_data, exp_q.pop_front());
                    end
                end
                step();
            end
            check("stream_all_out", exp_q.size(), 32'd0);
            check("stream_idle", {31'd0, out_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
